// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_seq
// Purpose  : Bit-serial WIDTH-bit adder/subtractor built on one full-adder
//            cell. Operands are latched on an accepted start. One bit is
//            resolved per clock, LSB first. Sum, carry-out and signed
//            overflow are registered and held until the next completion.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            start_i    - request an operation (honoured only when not busy)
//            a_i, b_i   - WIDTH-bit operands, sampled with start_i
//            cin_i      - carry-in (add mode only), sampled with start_i
//            sub_i      - 0: a+b+cin, 1: a-b, sampled with start_i
//            busy_o     - operation in progress
//            done_o     - one-cycle pulse when results update
//            sum_o      - WIDTH-bit result
//            carry_o    - carry-out of MSB (sub mode: 1 = no borrow)
//            overflow_o - two's-complement overflow of the result
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int                 C_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  // The single full-adder cell working on the LSBs of the shift registers.
  logic w_s;
  logic w_cout;
  logic [WIDTH-1:0] w_res_next;

  assign w_s        = a_q[0] ^ b_q[0] ^ c_q;
  assign w_cout     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next = {w_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      C_IDLE, C_DONE: begin
        if (start_i) begin
          a_d     = a_i;
          // Subtraction as a + ~b + 1: invert B and force the initial carry.
          b_d     = sub_i ? ~b_i : b_i;
          c_d     = sub_i ? 1'b1 : cin_i;
          cnt_d   = '0;
          state_d = C_RUN;
        end else begin
          state_d = C_IDLE;
        end
      end

      C_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = w_cout;
        cnt_d = cnt_q + C_CNT_ONE;
        res_d = w_res_next;
        if (cnt_q == C_CNT_LAST) begin
          sum_d   = w_res_next;
          carry_d = w_cout;
          // Carry into the MSB differs from carry out of it on signed overflow.
          ovf_d   = c_q ^ w_cout;
          state_d = C_DONE;
        end
      end

      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q == C_RUN);
  assign done_o     = (state_q == C_DONE);
  assign sum_o      = sum_q;
  assign carry_o    = carry_q;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire
